fp_mul_pipe: RTL and testbench
==============================

// Module: fp_mul_pipe
// PURPOSE
//  Pipelined IEEE-754-style floating-point multiplier with a valid/ready handshake, for the FFT twiddle/butterfly datapath.
//  Generalised in exponent and mantissa width. Adds round-to-nearest-even, special-value handling, exception flags,
//  a passthrough tag and backpressure. Throughput is one result per clock while out_ready is high.
// PARAMETERS
//  EXP_W   8   exponent field width; BIAS = 2**(EXP_W-1)-1
//  MAN_W   23  stored fraction width (hidden bit not stored)
//  TAG_W   4   sideband tag width, carried unchanged alongside the data
//  Derived: W = 1+EXP_W+MAN_W (word width)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block can accept an operand pair
//  in_a       in   W      operand A {sign,exp,frac}
//  in_b       in   W      operand B
//  in_tag     in   TAG_W  sideband tag
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts the result
//  out_p      out  W      product
//  out_tag    out  TAG_W  tag of this result
//  out_flags  out  4      {invalid, overflow, underflow, inexact}
// BEHAVIOUR
//  - Reset: all stage valids, out_valid, out_p, out_tag and out_flags go to 0. In-flight data is discarded, also mid-operation.
//  - Stall: en = !out_valid | out_ready. in_ready = en (combinational from out_ready). All stages advance only when en=1.
//  - Transfer: an input transfers on in_valid&in_ready. An output transfers on out_valid&out_ready.
//  - Latency: an operand accepted at edge N is presented on out_* after edge N+2 (3 register stages), absent stalls.
//  - Ordering: results are strictly in order. No result is dropped or duplicated under any out_ready pattern.
//  - While stalled, out_p/out_tag/out_flags hold stable.
//  - S1 (unpack/classify): classify each operand as ZERO (exp=0; subnormals flush to zero), INF, NAN or NORM.
//    S1 also forms sign = a.s^b.s, mantissas {1,frac}, and exponent sum.
//    The exponent sum is a.e + b.e - BIAS in signed EXP_W+2 bits, so it never wraps.
//  - S2: full (MAN_W+1)x(MAN_W+1) product, 2*MAN_W+2 bits. Class and exponent are pipelined alongside.
//  - S3 (normalise/round/pack):
//    - If the product MSB is set: shift right by 1 and add 1 to the exponent.
//    - Round to nearest even using guard, round and sticky bits.
//    - A rounding carry-out renormalises: fraction becomes 0 and the exponent increments.
//  - Special results, in priority order:
//    - NAN operand, or INF*ZERO: canonical qNaN {0, all-ones, 1, 0...}. invalid=1 only for INF*ZERO or a signalling NaN.
//    - INF operand: signed infinity, no flags.
//    - ZERO operand: signed zero, no flags.
//    - Final exponent >= 2**EXP_W-1: signed infinity, overflow=1, inexact=1.
//    - Final exponent <= 0: signed zero (flush-to-zero), underflow=1, inexact=1.
//    - Otherwise inexact = guard|round|sticky.
//  - Flags are per-result, not sticky.
// STRUCTURE
//  - Package fp_pkg:
//    - class enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN}
//    - flag bit index constants (FLG_INV=3, FLG_OVF=2, FLG_UNF=1, FLG_INX=0)
//    - function fp_bias(EXP_W)
//    - function for the canonical qNaN
//  - Sub-module fp_round_pack: S3 combinational logic.
//    - Inputs: sign, exponent, product, class.
//    - Outputs: packed word and flags.
//  - The top level holds the handshake, the stage registers and the S1/S2 logic.
// TESTING
//  - Basic product, default parameters: in_a=0x3F100000 (0.5625), in_b=0x411C0000 (9.75).
//    Required: out_p=0x40AF8000, flags=0. out_valid after edge N+2.
//  - Rounding: 0x3F800001 * 0x3F800001. Required: out_p=0x3F800002, flags=0001 (inexact).
//  - Overflow and invalid:
//    - 0x7F000000 * 0x7F000000 -> out_p=0x7F800000, flags=0101.
//    - 0x7F800000 * 0x80000000 -> out_p=0x7FC00000, flags=1000.
//  - Underflow: 0x00800000 * 0x00800000 -> out_p=0x00000000, flags=0011.
//    Subnormal 0x00000001 * 0x3F800000 -> 0x00000000, flags=0000.
//  - Backpressure: stream 6 tagged ops back-to-back, with out_ready low for cycles 3-8.
//    Required: in_ready low while stalled, 6 results in tag order, none lost or duplicated, outputs stable while stalled.
//  - Reset mid-stream: assert rst_n=0 with 3 ops in flight.
//    Required: out_valid=0 immediately (asynchronous), and no stale result emerges after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
// Operand classes, flag bit positions, bias and canonical quiet-NaN builders.
package fp_pkg;

   typedef enum logic [1:0] {
      FP_ZERO = 2'd0,
      FP_NORM = 2'd1,
      FP_INF  = 2'd2,
      FP_NAN  = 2'd3
   } fp_class_e;

   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_INX = 0;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Canonical qNaN {0, all-ones exponent, fraction MSB set}, right-aligned in 64 bits.
   function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
      r[man_w - 1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final stage: normalise the raw mantissa product, round to nearest even,
// resolve special classes and exponent range, and pack the result word with flags.
module fp_round_pack
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                      sign_i,
   input  logic signed [EXP_W+1:0]   exp_i,
   input  logic [2*MAN_W+1:0]        prod_i,
   input  fp_class_e                 cls_i,
   input  logic                      inv_i,
   output logic [EXP_W+MAN_W:0]      word_o,
   output logic [3:0]                flags_o
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int PW = 2 * MAN_W + 2;
   localparam int XW = EXP_W + 2;
   localparam logic [63:0] QNAN64 = fp_qnan(EXP_W, MAN_W);
   localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
   localparam logic signed [XW-1:0] EXP_MIN = '0;

   logic [PW-2:0]           norm;
   logic                    guard, rnd, sticky, round_up;
   logic [MAN_W:0]          frac_r;
   logic signed [XW-1:0]    exp_f;

   always_comb begin
      // Left-align so the hidden one is dropped and the fraction sits in the top MAN_W bits.
      norm     = prod_i[PW-1] ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
      guard    = norm[MAN_W];
      rnd      = norm[MAN_W-1];
      sticky   = |norm[MAN_W-2:0];
      round_up = guard & (rnd | sticky | norm[MAN_W+1]);
      frac_r   = {1'b0, norm[PW-2:MAN_W+1]} + (MAN_W+1)'(round_up);
      exp_f    = exp_i + XW'(prod_i[PW-1]) + XW'(frac_r[MAN_W]);

      word_o  = '0;
      flags_o = '0;
      case (cls_i)
         FP_NAN: begin
            word_o           = QNAN64[W-1:0];
            flags_o[FLG_INV] = inv_i;
         end
         FP_INF:  word_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         FP_ZERO: word_o = {sign_i, {(W-1){1'b0}}};
         default: begin
            if (exp_f >= EXP_MAX) begin
               word_o           = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               flags_o[FLG_OVF] = 1'b1;
               flags_o[FLG_INX] = 1'b1;
            end else if (exp_f <= EXP_MIN) begin
               word_o           = {sign_i, {(W-1){1'b0}}};
               flags_o[FLG_UNF] = 1'b1;
               flags_o[FLG_INX] = 1'b1;
            end else begin
               // A rounding carry leaves the low MAN_W bits of frac_r at zero.
               word_o           = {sign_i, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
               flags_o[FLG_INX] = guard | rnd | sticky;
            end
         end
      endcase
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier: unpack/classify, mantissa multiply,
// round/pack. A single enable stalls every stage together under backpressure.
module fp_mul_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [EXP_W+MAN_W:0]       in_a,
   input  logic [EXP_W+MAN_W:0]       in_b,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [EXP_W+MAN_W:0]       out_p,
   output logic [TAG_W-1:0]           out_tag,
   output logic [3:0]                 out_flags
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int PW   = 2 * MAN_W + 2;
   localparam int XW   = EXP_W + 2;
   localparam int BIAS = fp_bias(EXP_W);

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
      if (e == '0) return FP_ZERO;
      if (&e)      return (f == '0) ? FP_INF : FP_NAN;
      return FP_NORM;
   endfunction

   // Handshake: every stage moves when the output slot is empty or being drained.
   logic en;
   assign en       = !out_valid | out_ready;
   assign in_ready = en;

   // S1 combinational
   fp_class_e           cls_a, cls_b, cls_d;
   logic                inf_zero, inv_d, sign_d;
   logic signed [XW-1:0] exp_d;

   always_comb begin
      cls_a    = classify(in_a[W-2:MAN_W], in_a[MAN_W-1:0]);
      cls_b    = classify(in_b[W-2:MAN_W], in_b[MAN_W-1:0]);
      inf_zero = (cls_a == FP_INF && cls_b == FP_ZERO) || (cls_b == FP_INF && cls_a == FP_ZERO);
      inv_d    = inf_zero
               || (cls_a == FP_NAN && !in_a[MAN_W-1])
               || (cls_b == FP_NAN && !in_b[MAN_W-1]);
      sign_d   = in_a[W-1] ^ in_b[W-1];
      exp_d    = XW'(in_a[W-2:MAN_W]) + XW'(in_b[W-2:MAN_W]) - XW'(BIAS);
      cls_d    = FP_NORM;
      if (cls_a == FP_NAN || cls_b == FP_NAN || inf_zero) cls_d = FP_NAN;
      else if (cls_a == FP_INF || cls_b == FP_INF)         cls_d = FP_INF;
      else if (cls_a == FP_ZERO || cls_b == FP_ZERO)       cls_d = FP_ZERO;
   end

   // Stage registers
   logic                 v1_q, sign1_q, inv1_q;
   logic signed [XW-1:0] exp1_q;
   fp_class_e            cls1_q;
   logic [MAN_W:0]       ma1_q, mb1_q;
   logic [TAG_W-1:0]     tag1_q;

   logic                 v2_q, sign2_q, inv2_q;
   logic signed [XW-1:0] exp2_q;
   fp_class_e            cls2_q;
   logic [PW-1:0]        prod2_q;
   logic [TAG_W-1:0]     tag2_q;

   logic                 out_valid_q;
   logic [W-1:0]         out_p_q;
   logic [TAG_W-1:0]     out_tag_q;
   logic [3:0]           out_flags_q;

   logic [PW-1:0]        prod_d;
   logic [W-1:0]         word_d;
   logic [3:0]           flags_d;

   assign prod_d = PW'(ma1_q) * PW'(mb1_q);

   fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
      .sign_i  (sign2_q),
      .exp_i   (exp2_q),
      .prod_i  (prod2_q),
      .cls_i   (cls2_q),
      .inv_i   (inv2_q),
      .word_o  (word_d),
      .flags_o (flags_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         sign1_q     <= 1'b0;
         inv1_q      <= 1'b0;
         exp1_q      <= '0;
         cls1_q      <= FP_ZERO;
         ma1_q       <= '0;
         mb1_q       <= '0;
         tag1_q      <= '0;
         v2_q        <= 1'b0;
         sign2_q     <= 1'b0;
         inv2_q      <= 1'b0;
         exp2_q      <= '0;
         cls2_q      <= FP_ZERO;
         prod2_q     <= '0;
         tag2_q      <= '0;
         out_valid_q <= 1'b0;
         out_p_q     <= '0;
         out_tag_q   <= '0;
         out_flags_q <= '0;
      end else if (en) begin
         v1_q        <= in_valid;
         sign1_q     <= sign_d;
         inv1_q      <= inv_d;
         exp1_q      <= exp_d;
         cls1_q      <= cls_d;
         ma1_q       <= {1'b1, in_a[MAN_W-1:0]};
         mb1_q       <= {1'b1, in_b[MAN_W-1:0]};
         tag1_q      <= in_tag;
         v2_q        <= v1_q;
         sign2_q     <= sign1_q;
         inv2_q      <= inv1_q;
         exp2_q      <= exp1_q;
         cls2_q      <= cls1_q;
         prod2_q     <= prod_d;
         tag2_q      <= tag1_q;
         out_valid_q <= v2_q;
         if (v2_q) begin
            out_p_q     <= word_d;
            out_tag_q   <= tag2_q;
            out_flags_q <= flags_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_p     = out_p_q;
   assign out_tag   = out_tag_q;
   assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed vectors, backpressure, mid-stream reset and a
// randomized stream scored against an arithmetic reference model.
module tb_fp_mul_pipe;

   localparam int EW = 40;  // {product, tag, flags}

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_p;
   logic [3:0]  out_tag;
   logic [3:0]  out_flags;

   int check_cnt = 0;
   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int rx_cnt    = 0;

   logic [EW-1:0] exp_q[$];
   logic          hold_v = 1'b0;
   logic [EW-1:0] held;

   fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_tag   (out_tag),
      .out_flags (out_flags)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
      check_cnt++;
      assert (got === expv) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   // Reference: exact integer product, then nearest-even rounding by remainder comparison.
   function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      int           ea, eb, e, k, shift;
      logic         s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inf_zero, snan, inx;
      logic [63:0]  p, q, rem, half;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      s  = a[31] ^ b[31];
      a_nan  = (ea == 255) && (a[22:0] != 0);
      b_nan  = (eb == 255) && (b[22:0] != 0);
      a_inf  = (ea == 255) && (a[22:0] == 0);
      b_inf  = (eb == 255) && (b[22:0] == 0);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      inf_zero = (a_inf && b_zero) || (b_inf && a_zero);
      snan = (a_nan && !a[22]) || (b_nan && !b[22]);
      if (a_nan || b_nan || inf_zero) return {32'h7FC0_0000, (inf_zero || snan), 3'b000};
      if (a_inf || b_inf)             return {s, 8'hFF, 23'd0, 4'b0000};
      if (a_zero || b_zero)           return {s, 31'd0, 4'b0000};
      p = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
      k = 0;
      for (int i = 63; i >= 0; i--) if (p[i]) begin k = i; break; end
      e     = ea + eb - 127 + (k - 46);
      shift = k - 23;
      q     = p >> shift;
      rem   = p & ((64'd1 << shift) - 64'd1);
      half  = 64'd1 << (shift - 1);
      inx   = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'd0, 4'b0101};
      if (e <= 0)   return {s, 31'd0, 4'b0011};
      return {s, e[7:0], q[22:0], 3'b000, inx};
   endfunction

   function automatic logic [31:0] rand_op();
      logic       s;
      logic [7:0] e;
      logic [22:0] f;
      s = 1'($urandom_range(0, 1));
      f = 23'($urandom);
      case ($urandom_range(0, 19))
         0:       e = 8'd0;
         1:       begin e = 8'hFF; f = '0; end
         2:       begin e = 8'hFF; if (f == 0) f = 23'd1; end
         3, 4:    e = 8'($urandom_range(190, 254));
         5, 6:    e = 8'($urandom_range(1, 64));
         default: e = 8'($urandom_range(100, 154));
      endcase
      return {s, e, f};
   endfunction

   // One clock: score the values presented this cycle, then advance past the edge.
   task automatic cycle(output bit acc);
      logic [EW-1:0] e;
      logic [35:0]   r;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (hold_v) chk("hold_stable", {24'd0, out_p, out_tag, out_flags}, {24'd0, held});
      if (out_valid && !out_ready) begin
         chk("in_ready_stall", {63'd0, in_ready}, 64'd0);
         hold_v = 1'b1;
         held   = {out_p, out_tag, out_flags};
      end else begin
         hold_v = 1'b0;
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_result", {60'd0, out_tag}, 64'hDEAD);
         end else begin
            e = exp_q.pop_front();
            chk("result", {24'd0, out_p, out_tag, out_flags}, {24'd0, e});
            rx_cnt++;
         end
      end
      if (acc) begin
         r = ref_mul(in_a, in_b);
         exp_q.push_back({r[35:4], in_tag, r[3:0]});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_single(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] tag, input logic [31:0] exp_p, input logic [3:0] exp_f);
      bit acc;
      in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
      cycle(acc);
      chk({name, "_accept"}, {63'd0, acc}, 64'd1);
      in_valid = 1'b0;
      chk({name, "_lat_n"}, {63'd0, out_valid}, 64'd0);
      cycle(acc);
      chk({name, "_lat_n1"}, {63'd0, out_valid}, 64'd0);
      cycle(acc);
      chk({name, "_lat_n2"}, {63'd0, out_valid}, 64'd1);
      chk({name, "_p"}, {32'd0, out_p}, {32'd0, exp_p});
      chk({name, "_flags"}, {60'd0, out_flags}, {60'd0, exp_f});
      cycle(acc);
   endtask

   initial begin
      bit acc;
      int sent, cyc;

      // reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_p", {32'd0, out_p}, 64'd0);
      chk("rst_out_tag_flags", {56'd0, out_tag, out_flags}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // directed vectors
      run_single("basic",     32'h3F10_0000, 32'h411C_0000, 4'h1, 32'h40AF_8000, 4'b0000);
      run_single("round",     32'h3F80_0001, 32'h3F80_0001, 4'h2, 32'h3F80_0002, 4'b0001);
      run_single("overflow",  32'h7F00_0000, 32'h7F00_0000, 4'h3, 32'h7F80_0000, 4'b0101);
      run_single("inf_zero",  32'h7F80_0000, 32'h8000_0000, 4'h4, 32'h7FC0_0000, 4'b1000);
      run_single("underflow", 32'h0080_0000, 32'h0080_0000, 4'h5, 32'h0000_0000, 4'b0011);
      run_single("subnormal", 32'h0000_0001, 32'h3F80_0000, 4'h6, 32'h0000_0000, 4'b0000);
      run_single("tie_odd",   32'h3F80_0001, 32'h3FC0_0000, 4'h7, 32'h3FC0_0002, 4'b0001);
      run_single("tie_even",  32'h3F80_0003, 32'h3FC0_0000, 4'h8, 32'h3FC0_0004, 4'b0001);
      run_single("rnd_carry", 32'h3FFF_FFFF, 32'h3F80_0001, 4'h9, 32'h4000_0000, 4'b0001);
      run_single("snan",      32'h7F80_0001, 32'h3F80_0000, 4'hA, 32'h7FC0_0000, 4'b1000);
      run_single("qnan_neg",  32'hFFC0_0001, 32'h4000_0000, 4'hB, 32'h7FC0_0000, 4'b0000);
      run_single("neg_inf",   32'hFF80_0000, 32'h4000_0000, 4'hC, 32'hFF80_0000, 4'b0000);

      // backpressure: six tagged ops, output stalled on cycles 3..8
      rx_cnt = 0;
      sent = 0;
      for (int c = 0; c < 60 && (sent < 6 || exp_q.size() != 0); c++) begin
         out_ready = !(c >= 3 && c <= 8);
         in_valid  = (sent < 6);
         in_a      = 32'h3F80_0000 + 32'(sent * 32'h0001_1111);
         in_b      = 32'h4040_0000 + 32'(sent * 32'h0000_0777);
         in_tag    = 4'(sent);
         cycle(acc);
         if (acc) sent++;
      end
      in_valid = 1'b0;
      chk("bp_sent", 64'(sent), 64'd6);
      chk("bp_received", 64'(rx_cnt), 64'd6);
      chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

      // reset with three ops in flight
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_a     = rand_op();
         in_b     = rand_op();
         in_tag   = 4'(i + 4'hD);
         cycle(acc);
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("async_rst_p", {32'd0, out_p}, 64'd0);
      exp_q.delete();
      hold_v = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle(acc);
         chk("no_stale_result", {63'd0, out_valid}, 64'd0);
      end
      run_single("post_rst", 32'h3F10_0000, 32'h411C_0000, 4'h1, 32'h40AF_8000, 4'b0000);

      // randomized stream with random backpressure
      rx_cnt = 0;
      sent = 0;
      cyc = 0;
      in_valid = 1'b0;
      while (sent < 400 && cyc < 4000) begin
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a     = rand_op();
            in_b     = rand_op();
            in_tag   = 4'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         cycle(acc);
         if (acc) sent++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle(acc);
      chk("rand_sent", 64'(sent), 64'd400);
      chk("rand_received", 64'(rx_cnt), 64'd400);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
